// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: ROM address/data, branch redirect and decode handshake.
interface instr_fetch_unit_if;
   logic [7:0]  pc_out;
   logic [15:0] instr_in;
   logic        branch_valid;
   logic [7:0]  branch_target;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_instr;
   logic [7:0]  out_pc;

   // Fetch unit side
   modport master (
      output pc_out,
      input  instr_in,
      input  branch_valid,
      input  branch_target,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc
   );

   // ROM / decode / branch-unit side
   modport slave (
      input  pc_out,
      output instr_in,
      output branch_valid,
      output branch_target,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, one-deep in-flight tracker for a synchronous ROM
// and a 2-entry {instr, pc} buffer toward decode, with credit-based issue.
module instr_fetch_unit #(
   parameter logic [7:0] RESET_PC = 8'd0
) (
   input logic                   clk,
   input logic                   rst,
   instr_fetch_unit_if.master    bus
);

   logic [7:0]  pc_q, pc_d;
   logic        req_valid_q, req_valid_d;
   logic [7:0]  req_pc_q, req_pc_d;
   logic [1:0]  count_q, count_d;
   logic [15:0] instr_q [2];
   logic [15:0] instr_d [2];
   logic [7:0]  epc_q [2];
   logic [7:0]  epc_d [2];

   logic        out_valid_w;
   logic        pop;
   logic        issue;
   logic [1:0]  occ;

   assign out_valid_w = (count_q != 2'd0);
   assign pop         = out_valid_w & bus.out_ready;
   // Slots already committed after this edge; never exceeds 2 so FIFO cannot overflow
   assign occ         = count_q + {1'b0, req_valid_q} - {1'b0, pop};
   assign issue       = (occ < 2'd2);

   assign bus.pc_out    = pc_q;
   assign bus.out_valid = out_valid_w;
   assign bus.out_instr = out_valid_w ? instr_q[0] : 16'h0000;
   assign bus.out_pc    = out_valid_w ? epc_q[0] : 8'h00;

   // Next-state: branch overrides issue and FIFO update; entry 0 is always the head
   always_comb begin
      pc_d        = pc_q;
      req_valid_d = req_valid_q;
      req_pc_d    = req_pc_q;
      count_d     = count_q;
      instr_d     = instr_q;
      epc_d       = epc_q;

      if (bus.branch_valid) begin
         pc_d        = bus.branch_target;
         req_valid_d = 1'b0;
         count_d     = 2'd0;
      end else begin
         if (issue) begin
            req_valid_d = 1'b1;
            req_pc_d    = pc_q;
            pc_d        = pc_q + 8'd1;
         end else begin
            req_valid_d = 1'b0;
         end

         unique case ({req_valid_q, pop})
            2'b11: begin
               if (count_q == 2'd2) begin
                  instr_d[0] = instr_q[1];
                  epc_d[0]   = epc_q[1];
                  instr_d[1] = bus.instr_in;
                  epc_d[1]   = req_pc_q;
               end else begin
                  instr_d[0] = bus.instr_in;
                  epc_d[0]   = req_pc_q;
               end
            end
            2'b10: begin
               if (count_q == 2'd0) begin
                  instr_d[0] = bus.instr_in;
                  epc_d[0]   = req_pc_q;
               end else begin
                  instr_d[1] = bus.instr_in;
                  epc_d[1]   = req_pc_q;
               end
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               instr_d[0] = instr_q[1];
               epc_d[0]   = epc_q[1];
               count_d    = count_q - 2'd1;
            end
            default: ;
         endcase
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q        <= RESET_PC;
         req_valid_q <= 1'b0;
         req_pc_q    <= 8'h00;
         count_q     <= 2'd0;
         instr_q[0]  <= 16'h0000;
         instr_q[1]  <= 16'h0000;
         epc_q[0]    <= 8'h00;
         epc_q[1]    <= 8'h00;
      end else begin
         pc_q        <= pc_d;
         req_valid_q <= req_valid_d;
         req_pc_q    <= req_pc_d;
         count_q     <= count_d;
         instr_q     <= instr_d;
         epc_q       <= epc_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a synchronous ROM model word[a] = 16'hA000 | a.
module tb_instr_fetch_unit;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   instr_fetch_unit_if ifc ();

   instr_fetch_unit #(
      .RESET_PC (8'd0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM: data for the address sampled at this edge appears after it
   always @(posedge clk) ifc.instr_in <= 16'hA000 | {8'h00, ifc.pc_out};

   initial begin
      #100000;
      $display("FAIL watchdog: time limit expired, required $finish before 100000");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst                = 1'b0;
      ifc.branch_valid   = 1'b0;
      ifc.branch_target  = 8'h00;
      ifc.out_ready      = 1'b1;
      #3;  // before any clock edge
      checks += 4;
      if (ifc.pc_out !== 8'h00) begin
         errors++; $display("FAIL reset_pc_out: got %h want 00", ifc.pc_out);
      end
      if (ifc.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid: got %b want 0", ifc.out_valid);
      end
      if (ifc.out_instr !== 16'h0000) begin
         errors++; $display("FAIL reset_out_instr: got %h want 0000", ifc.out_instr);
      end
      if (ifc.out_pc !== 8'h00) begin
         errors++; $display("FAIL reset_out_pc: got %h want 00", ifc.out_pc);
      end
      step();
      step();
   endtask

   // Release reset and check PC advance, 2-edge latency and 1 word/cycle
   task automatic test_stream();
      @(negedge clk);
      rst = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         checks += 2;
         if (ifc.pc_out !== 8'(k)) begin
            errors++; $display("FAIL stream_pc_out[%0d]: got %h want %h", k, ifc.pc_out, 8'(k));
         end
         if (ifc.out_valid !== (k >= 2)) begin
            errors++; $display("FAIL stream_valid[%0d]: got %b want %b", k, ifc.out_valid, k >= 2);
         end
         if (k >= 2) begin
            checks += 2;
            if (ifc.out_pc !== 8'(k - 2)) begin
               errors++; $display("FAIL stream_out_pc[%0d]: got %h want %h", k, ifc.out_pc, 8'(k - 2));
            end
            if (ifc.out_instr !== (16'hA000 | 16'(k - 2))) begin
               errors++; $display("FAIL stream_out_instr[%0d]: got %h want %h", k, ifc.out_instr,
                                  16'hA000 | 16'(k - 2));
            end
         end
      end
   endtask

   // Stall 5 cycles with head=6, PC=8; then resume 7,8,9,... with no gap
   task automatic test_backpressure();
      ifc.out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         checks += 4;
         if (ifc.pc_out !== 8'h08) begin
            errors++; $display("FAIL bp_pc_hold[%0d]: got %h want 08", k, ifc.pc_out);
         end
         if (ifc.out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_valid[%0d]: got %b want 1", k, ifc.out_valid);
         end
         if (ifc.out_pc !== 8'h06) begin
            errors++; $display("FAIL bp_out_pc[%0d]: got %h want 06", k, ifc.out_pc);
         end
         if (ifc.out_instr !== 16'hA006) begin
            errors++; $display("FAIL bp_out_instr[%0d]: got %h want A006", k, ifc.out_instr);
         end
      end
      ifc.out_ready = 1'b1;
      for (int j = 1; j <= 5; j++) begin
         step();
         checks += 4;
         if (ifc.out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_resume_valid[%0d]: got %b want 1", j, ifc.out_valid);
         end
         if (ifc.out_pc !== 8'(6 + j)) begin
            errors++; $display("FAIL bp_resume_pc[%0d]: got %h want %h", j, ifc.out_pc, 8'(6 + j));
         end
         if (ifc.out_instr !== (16'hA000 | 16'(6 + j))) begin
            errors++; $display("FAIL bp_resume_instr[%0d]: got %h want %h", j, ifc.out_instr,
                               16'hA000 | 16'(6 + j));
         end
         if (ifc.pc_out !== 8'(8 + j)) begin
            errors++; $display("FAIL bp_resume_pc_out[%0d]: got %h want %h", j, ifc.pc_out, 8'(8 + j));
         end
      end
   endtask

   // Fill FIFO to 2 (heads 11,12) then branch to 40 with out_ready=0
   task automatic test_branch_full();
      ifc.out_ready = 1'b0;
      step();
      step();
      checks += 2;
      if (ifc.out_pc !== 8'h0B) begin
         errors++; $display("FAIL brf_pre_head: got %h want 0B", ifc.out_pc);
      end
      if (ifc.pc_out !== 8'h0D) begin
         errors++; $display("FAIL brf_pre_pc_out: got %h want 0D", ifc.pc_out);
      end
      ifc.branch_valid  = 1'b1;
      ifc.branch_target = 8'h40;
      step();
      ifc.branch_valid  = 1'b0;
      ifc.out_ready     = 1'b1;
      checks += 2;
      if (ifc.out_valid !== 1'b0) begin
         errors++; $display("FAIL brf_flush_valid: got %b want 0", ifc.out_valid);
      end
      if (ifc.pc_out !== 8'h40) begin
         errors++; $display("FAIL brf_pc_target: got %h want 40", ifc.pc_out);
      end
      step();
      checks += 2;
      if (ifc.out_valid !== 1'b0) begin
         errors++; $display("FAIL brf_gap_valid: got %b want 0", ifc.out_valid);
      end
      if (ifc.pc_out !== 8'h41) begin
         errors++; $display("FAIL brf_pc_next: got %h want 41", ifc.pc_out);
      end
      step();
      checks += 3;
      if (ifc.out_valid !== 1'b1) begin
         errors++; $display("FAIL brf_first_valid: got %b want 1", ifc.out_valid);
      end
      if (ifc.out_pc !== 8'h40) begin
         errors++; $display("FAIL brf_first_pc: got %h want 40", ifc.out_pc);
      end
      if (ifc.out_instr !== 16'hA040) begin
         errors++; $display("FAIL brf_first_instr: got %h want A040", ifc.out_instr);
      end
      step();
   endtask

   // Head 41 is popped on the same edge as a branch to 80
   task automatic test_branch_pop();
      checks += 2;
      if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 8'h41) begin
         errors++; $display("FAIL brp_pre_head: got v=%b pc=%h want v=1 pc=41", ifc.out_valid,
                            ifc.out_pc);
      end
      if (ifc.out_instr !== 16'hA041) begin
         errors++; $display("FAIL brp_pre_instr: got %h want A041", ifc.out_instr);
      end
      ifc.branch_valid  = 1'b1;
      ifc.branch_target = 8'h80;
      step();
      ifc.branch_valid  = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (ifc.out_valid !== 1'b0) begin
            errors++; $display("FAIL brp_gap_valid[%0d]: got %b (pc %h) want 0", k, ifc.out_valid,
                               ifc.out_pc);
         end
         step();
      end
      checks += 3;
      if (ifc.out_valid !== 1'b1) begin
         errors++; $display("FAIL brp_next_valid: got %b want 1", ifc.out_valid);
      end
      if (ifc.out_pc !== 8'h80) begin
         errors++; $display("FAIL brp_next_pc: got %h want 80", ifc.out_pc);
      end
      if (ifc.out_instr !== 16'hA080) begin
         errors++; $display("FAIL brp_next_instr: got %h want A080", ifc.out_instr);
      end
   endtask

   // Branch to FE; presented sequence FE, FF, 00, 01
   task automatic test_wrap();
      logic [7:0] exp_pc [4];
      exp_pc[0] = 8'hFE;
      exp_pc[1] = 8'hFF;
      exp_pc[2] = 8'h00;
      exp_pc[3] = 8'h01;
      ifc.branch_valid  = 1'b1;
      ifc.branch_target = 8'hFE;
      step();
      ifc.branch_valid  = 1'b0;
      step();
      step();
      for (int k = 0; k < 4; k++) begin
         checks += 3;
         if (ifc.out_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_valid[%0d]: got %b want 1", k, ifc.out_valid);
         end
         if (ifc.out_pc !== exp_pc[k]) begin
            errors++; $display("FAIL wrap_pc[%0d]: got %h want %h", k, ifc.out_pc, exp_pc[k]);
         end
         if (ifc.out_instr !== (16'hA000 | {8'h00, exp_pc[k]})) begin
            errors++; $display("FAIL wrap_instr[%0d]: got %h want %h", k, ifc.out_instr,
                               16'hA000 | {8'h00, exp_pc[k]});
         end
         step();
      end
   endtask

   // Assert reset between edges; outputs clear immediately, stream restarts from 0
   task automatic test_async_reset();
      step();
      rst = 1'b0;
      #2;
      checks += 4;
      if (ifc.pc_out !== 8'h00) begin
         errors++; $display("FAIL arst_pc_out: got %h want 00", ifc.pc_out);
      end
      if (ifc.out_valid !== 1'b0) begin
         errors++; $display("FAIL arst_out_valid: got %b want 0", ifc.out_valid);
      end
      if (ifc.out_instr !== 16'h0000) begin
         errors++; $display("FAIL arst_out_instr: got %h want 0000", ifc.out_instr);
      end
      if (ifc.out_pc !== 8'h00) begin
         errors++; $display("FAIL arst_out_pc: got %h want 00", ifc.out_pc);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         checks += 2;
         if (ifc.pc_out !== 8'(k)) begin
            errors++; $display("FAIL arst_restart_pc_out[%0d]: got %h want %h", k, ifc.pc_out, 8'(k));
         end
         if (ifc.out_valid !== (k >= 2)) begin
            errors++; $display("FAIL arst_restart_valid[%0d]: got %b want %b", k, ifc.out_valid,
                               k >= 2);
         end
         if (k >= 2) begin
            checks++;
            if (ifc.out_pc !== 8'(k - 2) || ifc.out_instr !== (16'hA000 | 16'(k - 2))) begin
               errors++; $display("FAIL arst_restart_word[%0d]: got pc=%h instr=%h want pc=%h",
                                  k, ifc.out_pc, ifc.out_instr, 8'(k - 2));
            end
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_stream();
      test_backpressure();
      test_branch_full();
      test_branch_pop();
      test_wrap();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
